// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Multi-cycle unsigned subtractor: D = A - B computed one 4-bit nibble per
// clock, LSB nibble first, through a single reused 4-bit add stage
// (A + ~B + carry). A start/busy/done handshake talks to the controlling FSM.
// WIDTH must be a multiple of 4 and at least 4.
// Optional feature macro: SUB_OVERFLOW_FLAG_EN adds the signed overflow
// output ovf, updated together with D.

module nibble_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             borrow,
`ifdef SUB_OVERFLOW_FLAG_EN
   output logic             zero,
   output logic             ovf
`else
   output logic             zero
`endif
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic [WIDTH-1:0] r_shadow;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_d;
   logic             r_borrow;
   logic             r_zero;
`ifdef SUB_OVERFLOW_FLAG_EN
   logic             r_ovf;
`endif

   logic [3:0]       w_aNib;
   logic [3:0]       w_bNib;
   logic [4:0]       w_sum;
   logic [WIDTH-1:0] w_result;
   logic             w_accept;
   logic             w_lastNib;

   // Pick the nibble pair currently addressed by the nibble index
   always_comb begin
      w_aNib = 4'h0;
      w_bNib = 4'h0;
      for (int i = 0; i < NIB; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_aNib = r_opA[i*4 +: 4];
            w_bNib = r_opB[i*4 +: 4];
         end
      end
   end

   // The one shared 4-bit stage: subtraction as A + ~B + carry-in
   always_comb begin
      w_sum = {1'b0, w_aNib} + {1'b0, ~w_bNib} + {4'b0000, r_carry};
   end

   // Shadow result with the nibble being produced this cycle already merged in,
   // so the final edge can publish the complete difference in one step
   always_comb begin
      w_result = r_shadow;
      for (int i = 0; i < NIB; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_result[i*4 +: 4] = w_sum[3:0];
         end
      end
   end

   assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_lastNib = (r_idx == IDX_LAST);

   // Control FSM, operand capture, nibble stepping and registered results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_opA    <= '0;
         r_opB    <= '0;
         r_shadow <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_d      <= '0;
         r_borrow <= 1'b0;
         r_zero   <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_opA    <= A;
                  r_opB    <= B;
                  r_shadow <= '0;
                  r_idx    <= '0;
                  r_carry  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_shadow <= w_result;
               r_carry  <= w_sum[4];
               r_idx    <= r_idx + IDX_ONE;
               if (w_lastNib) begin
                  r_d      <= w_result;
                  r_borrow <= ~w_sum[4];
                  r_zero   <= (w_result == '0);
`ifdef SUB_OVERFLOW_FLAG_EN
                  r_ovf    <= (r_opA[WIDTH-1] != r_opB[WIDTH-1]) &&
                              (w_result[WIDTH-1] != r_opA[WIDTH-1]);
`endif
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign D      = r_d;
   assign borrow = r_borrow;
   assign zero   = r_zero;
`ifdef SUB_OVERFLOW_FLAG_EN
   assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor
// Self-checking bench for nibble_serial_subtractor (WIDTH=8, two nibbles).
// Table-driven vectors plus hand-written back-to-back, ignore-in-RUN and
// mid-operation reset sequences; expected results go through a queue.
// Define SUB_OVERFLOW_FLAG_EN to also check the ovf output.

module tb_nibble_serial_subtractor;

   localparam int WIDTH = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       brw;
      logic       zr;
      logic       ov;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic [7:0] D;
   logic       borrow;
   logic       zero;
`ifdef SUB_OVERFLOW_FLAG_EN
   logic       ovf;
`endif

   int   nApplied    = 0;
   int   nMiscompare = 0;
   vec_t sbQueue[$];
   vec_t vecs[10];

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .D      (D),
      .borrow (borrow),
`ifdef SUB_OVERFLOW_FLAG_EN
      .zero   (zero),
      .ovf    (ovf)
`else
      .zero   (zero)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiscompare++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                                  input logic brw, input logic zr, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.d = d; v.brw = brw; v.zr = zr; v.ov = ov;
      return v;
   endfunction

   // Drive one start pulse at the current negedge and record the expected result
   task automatic applyStimulus(input vec_t v);
      A     = v.a;
      B     = v.b;
      start = 1'b1;
      sbQueue.push_back(v);
   endtask

   // Pop the oldest expected result and compare it against the result outputs
   task automatic checkOutput(input string tag);
      vec_t e;
      nApplied++;
      if (sbQueue.size() == 0) begin
         nMiscompare++;
         $display("[TB] FAIL %s_queue: got result with no pending op, expected a pending op", tag);
      end else begin
         nApplied--;
         e = sbQueue.pop_front();
         checkVal({tag, "_D"}, 32'(D), 32'(e.d));
         checkVal({tag, "_borrow"}, 32'(borrow), 32'(e.brw));
         checkVal({tag, "_zero"}, 32'(zero), 32'(e.zr));
`ifdef SUB_OVERFLOW_FLAG_EN
         checkVal({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
      end
   endtask

   // One full operation with cycle-exact handshake checks, starting at a negedge
   task automatic runOp(input vec_t v, input string tag);
      applyStimulus(v);
      @(negedge clk);
      start = 1'b0;
      checkVal({tag, "_busy1"}, 32'(busy), 32'd1);
      checkVal({tag, "_done1"}, 32'(done), 32'd0);
      @(negedge clk);
      checkVal({tag, "_busy2"}, 32'(busy), 32'd1);
      checkVal({tag, "_done2"}, 32'(done), 32'd0);
      @(negedge clk);
      checkVal({tag, "_done3"}, 32'(done), 32'd1);
      checkVal({tag, "_busy3"}, 32'(busy), 32'd0);
      checkOutput(tag);
      @(negedge clk);
      checkVal({tag, "_doneOff"}, 32'(done), 32'd0);
      checkVal({tag, "_Dhold"}, 32'(D), 32'(v.d));
   endtask

   initial begin
      vecs[0] = mkVec(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
      vecs[1] = mkVec(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
      vecs[2] = mkVec(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      vecs[3] = mkVec(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0);
      vecs[4] = mkVec(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
      vecs[5] = mkVec(8'h20, 8'h01, 8'h1F, 1'b0, 1'b0, 1'b0);
      vecs[6] = mkVec(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);
      vecs[7] = mkVec(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
      vecs[8] = mkVec(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
      vecs[9] = mkVec(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 1'b0);

      reset = 1'b1;
      start = 1'b0;
      A     = 8'h00;
      B     = 8'h00;
      repeat (2) @(negedge clk);
      checkVal("rst_busy", 32'(busy), 32'd0);
      checkVal("rst_done", 32'(done), 32'd0);
      checkVal("rst_D", 32'(D), 32'd0);
      checkVal("rst_borrow", 32'(borrow), 32'd0);
      checkVal("rst_zero", 32'(zero), 32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
      checkVal("rst_ovf", 32'(ovf), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         runOp(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back: start held through DONE, operands swapped mid-RUN
      applyStimulus(vecs[3]);
      @(negedge clk);
      checkVal("b2b_busyA", 32'(busy), 32'd1);
      A = 8'hFF;
      B = 8'h01;
      sbQueue.push_back(vecs[4]);
      @(negedge clk);
      checkVal("b2b_busyA2", 32'(busy), 32'd1);
      @(negedge clk);
      checkVal("b2b_doneA", 32'(done), 32'd1);
      checkOutput("b2bA");
      @(negedge clk);
      start = 1'b0;
      checkVal("b2b_noIdle_busy", 32'(busy), 32'd1);
      checkVal("b2b_noIdle_done", 32'(done), 32'd0);
      @(negedge clk);
      checkVal("b2b_busyB2", 32'(busy), 32'd1);
      @(negedge clk);
      checkVal("b2b_doneB", 32'(done), 32'd1);
      checkOutput("b2bB");
      @(negedge clk);

      // start pulse and operand changes during RUN must be ignored
      applyStimulus(vecs[5]);
      @(negedge clk);
      start = 1'b1;
      A     = 8'hFF;
      B     = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      checkVal("ign_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkVal("ign_done", 32'(done), 32'd1);
      checkOutput("ign");
      @(negedge clk);
      checkVal("ign_idle_busy", 32'(busy), 32'd0);
      checkVal("ign_idle_done", 32'(done), 32'd0);

      // Asynchronous reset in the first RUN cycle discards the operation
      A     = 8'h35;
      B     = 8'h12;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkVal("mid_busyBefore", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkVal("mid_busy", 32'(busy), 32'd0);
      checkVal("mid_done", 32'(done), 32'd0);
      checkVal("mid_D", 32'(D), 32'd0);
      checkVal("mid_borrow", 32'(borrow), 32'd0);
      checkVal("mid_zero", 32'(zero), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkVal("mid_noDone", 32'(done), 32'd0);
         checkVal("mid_noBusy", 32'(busy), 32'd0);
      end
      runOp(vecs[6], "postRst");

      checkVal("queue_empty", 32'(sbQueue.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
      $finish;
   end

endmodule
